// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and parity helper.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int PAR_MAX_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Callers zero-extend their data word; the extra zeros do not change parity.
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Read-side port of the TX FIFO: the UART engine pops, the FIFO supplies data and empty.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;

  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit clock counter; bit_tick marks the last clk cycle of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_tick
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops one byte per frame from the TX FIFO and serialises it on tx.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_fifo_drain_if.master  fifo_if,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int               BIT_W     = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 2;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  timer_clr;
  logic                  bit_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timer_clr),
    .bit_tick (bit_tick)
  );

  assign fifo_if.fifo_rd_en = (state_q == ST_POP);
  assign busy               = (state_q != ST_IDLE);
  assign tx                 = tx_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    par_d     = par_q;
    timer_clr = 1'b0;
    tx_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_clr = 1'b1;
        if (!fifo_if.fifo_empty) state_d = ST_POP;
      end
      ST_POP: begin
        timer_clr = 1'b1;
        state_d   = ST_LOAD;
      end
      // FIFO dout is valid now, one cycle after the pop strobe.
      ST_LOAD: begin
        timer_clr = 1'b1;
        shift_d   = fifo_if.fifo_dout;
        par_d     = parity_bit(PAR_MAX_W'(fifo_if.fifo_dout), PARITY_ODD != 0);
        bit_d     = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            tx_done = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the state being entered so it lines up with state_q.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four configurations, each fed by a small FIFO model.
module tb_uart_tx_fifo_drain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) fif [4] ();

  logic [3:0] tx_w, busy_w, done_w, rd_w;
  logic [7:0] mem [4][16];
  logic [4:0] wp [4] = '{default: 5'd0};
  int         rd_cnt [4] = '{default: 0};
  int         rd_in_rst = 0;
  int         total = 0;
  int         bad = 0;

  // FIFO models: registered dout, empty flag lagging the count by one cycle.
  for (genvar k = 0; k < 4; k++) begin : g_fifo
    logic [4:0] rp      = 5'd0;
    logic [7:0] dout_q  = 8'd0;
    logic       empty_q = 1'b1;
    always @(posedge clk) begin
      if (fif[k].fifo_rd_en && (rp != wp[k])) begin
        dout_q <= mem[k][rp[3:0]];
        rp     <= rp + 5'd1;
      end
      empty_q <= (rp == wp[k]);
    end
    assign fif[k].fifo_empty = empty_q;
    assign fif[k].fifo_dout  = dout_q;
    assign rd_w[k]           = fif[k].fifo_rd_en;
  end

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_d0 (.clk(clk), .reset(rst), .fifo_if(fif[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    u_d1 (.clk(clk), .reset(rst), .fifo_if(fif[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_d2 (.clk(clk), .reset(rst), .fifo_if(fif[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(868), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_d3 (.clk(clk), .reset(rst), .fifo_if(fif[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (rd_w[j]) rd_cnt[j] <= rd_cnt[j] + 1;
    if (rst && (rd_w != 4'b0000)) rd_in_rst <= rd_in_rst + 1;
  end

  typedef struct {
    int          k;
    logic [7:0]  data;
    logic [11:0] frame;   // tx level per bit period, index 0 = start bit
    int          nbits;
    int          cpb;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    mem[k][wp[k][3:0]] = d;
    wp[k] = wp[k] + 5'd1;
  endtask

  // Waits for the start bit, checks every cycle of the frame, then the first idle cycle.
  task automatic run_frame(input int k, input logic [11:0] frame, input int nbits,
                           input int cpb, input string nm, output int waited);
    int found, bit_mask, done_hits, done_ok, busy_err, bit_bad;
    waited = 0;
    found  = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (tx_w[k] == 1'b0) begin
        found = 1;
        break;
      end
      waited++;
    end
    chk({nm, " start seen"}, found, 1);
    if (found == 0) return;
    bit_mask = 0; done_hits = 0; done_ok = 0; busy_err = 0;
    for (int i = 0; i < nbits; i++) begin
      bit_bad = 0;
      for (int c = 0; c < cpb; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (tx_w[k] !== frame[i]) bit_bad = 1;
        if (busy_w[k] !== 1'b1) busy_err++;
        if (done_w[k] === 1'b1) begin
          done_hits++;
          if (i == nbits - 1 && c == cpb - 1) done_ok = 1;
        end
      end
      if (bit_bad != 0) bit_mask |= (1 << i);
    end
    chk({nm, " bad bit mask"}, bit_mask, 0);
    chk({nm, " tx_done pulses"}, done_hits, 1);
    chk({nm, " tx_done on last cycle"}, done_ok, 1);
    chk({nm, " busy low in frame"}, busy_err, 0);
    @(negedge clk);
    chk({nm, " busy after frame"}, int'(busy_w[k]), 0);
    chk({nm, " tx idle after frame"}, int'(tx_w[k]), 1);
  endtask

  vec_t vecs [5];
  int   w, r0, idle_err;

  initial begin
    vecs[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 4};
    vecs[1] = '{1, 8'h07, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 12, 4};  // even parity = 1, 2 stops
    vecs[2] = '{1, 8'h03, {1'b1, 1'b1, 1'b0, 8'h03, 1'b0}, 12, 4};  // even parity = 0
    vecs[3] = '{2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 4};  // odd parity = 0
    vecs[4] = '{3, 8'h55, {2'b00, 1'b1, 8'h55, 1'b0}, 10, 868};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", int'(tx_w), 15);
    chk("reset busy", int'(busy_w), 0);
    chk("reset tx_done", int'(done_w), 0);
    chk("reset rd_en", int'(rd_w), 0);
    rst = 1'b0;

    r0 = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
    idle_err = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (tx_w != 4'hF || busy_w != 4'h0 || done_w != 4'h0) idle_err++;
    end
    chk("idle empty outputs", idle_err, 0);
    chk("idle empty pops", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - r0, 0);

    for (int v = 0; v < 5; v++) begin
      r0 = rd_cnt[vecs[v].k];
      push(vecs[v].k, vecs[v].data);
      run_frame(vecs[v].k, vecs[v].frame, vecs[v].nbits, vecs[v].cpb, $sformatf("vec%0d", v), w);
      chk($sformatf("vec%0d pops", v), rd_cnt[vecs[v].k] - r0, 1);
    end

    // Back-to-back frames from a FIFO holding two bytes.
    r0 = rd_cnt[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    run_frame(0, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 4, "b2b first", w);
    run_frame(0, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 4, "b2b second", w);
    chk("b2b idle-high gap", w + 1, 3);
    repeat (20) @(negedge clk);
    chk("b2b pops", rd_cnt[0] - r0, 2);
    chk("b2b idle busy", int'(busy_w[0]), 0);

    // Reset asserted mid-frame during data bit 3 of 0x3C.
    r0 = rd_cnt[0];
    push(0, 8'h3C);
    push(0, 8'h81);
    w = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (tx_w[0] == 1'b0) break;
      w++;
    end
    chk("rst test start seen", int'(w < 64), 1);
    repeat (17) @(negedge clk);
    chk("pre-reset busy", int'(busy_w[0]), 1);
    chk("pre-reset tx bit3", int'(tx_w[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset tx", int'(tx_w[0]), 1);
    chk("async reset busy", int'(busy_w[0]), 0);
    chk("async reset tx_done", int'(done_w[0]), 0);
    chk("async reset rd_en", int'(rd_w[0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_frame(0, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 4, "after reset", w);
    chk("reset test pops", rd_cnt[0] - r0, 2);
    chk("rd_en during reset", rd_in_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
